// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for MUL/MULH/MULHSU/MULHU with a stall/writeback controller.
// Operands are reduced to magnitudes at capture; the sign is applied once on the final product.
module mul_sequencer #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [1:0]        mul_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [2*DATA_W-1:0] ACC_ONE  = (2*DATA_W)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_W-1:0]     result_q, result_d;

  logic                  a_signed, b_signed;
  logic [DATA_W:0]       upper_sum;
  logic [2*DATA_W-1:0]   acc_step;

  // Two's-complement negation of the most negative value yields 2^(DATA_W-1), read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return (is_signed && v[DATA_W-1]) ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] select_result(input logic [2*DATA_W-1:0] acc,
                                                      input logic neg,
                                                      input logic [1:0] op);
    logic [2*DATA_W-1:0] p;
    p = neg ? (~acc + ACC_ONE) : acc;
    return (op == 2'b00) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
  endfunction

  assign a_signed = (mul_op == 2'b01) || (mul_op == 2'b10);
  assign b_signed = (mul_op == 2'b01);

  always_comb begin
    upper_sum = acc_q[0] ? ({1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mcand_q})
                         : {1'b0, acc_q[2*DATA_W-1:DATA_W]};
    acc_step  = {upper_sum, acc_q[DATA_W-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          state_d = S_CALC;
          mcand_d = magnitude(operand_a, a_signed);
          acc_d   = {{DATA_W{1'b0}}, magnitude(operand_b, b_signed)};
          neg_d   = (a_signed & operand_a[DATA_W-1]) ^ (b_signed & operand_b[DATA_W-1]);
          op_d    = mul_op;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        if (enable) begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_ONE;
          // The final step and the result capture share one edge, so DONE follows the last step directly.
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            result_d = select_result(acc_step, neg_q, op_q);
          end
        end
      end
      S_DONE: begin
        if (enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign stall        = (start && enable && (state_q == S_IDLE)) || (state_q == S_CALC);
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scenario bench for mul_sequencer: expected products are queued at issue and popped on result_valid.
module tb_mul_sequencer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         enable;
  logic         start;
  logic [1:0]   mul_op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         stall;
  logic         result_valid;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb_q[$];

  mul_sequencer #(.DATA_W(W)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .enable       (enable),
    .start        (start),
    .mul_op       (mul_op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [2*W:0] sa, sb, p;
    sa = (op == 2'b01 || op == 2'b10) ? {{(W+1){a[W-1]}}, a} : {{(W+1){1'b0}}, a};
    sb = (op == 2'b01) ? {{(W+1){b[W-1]}}, b} : {{(W+1){1'b0}}, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] pop_expected();
    return (sb_q.size() != 0) ? sb_q.pop_front() : '0;
  endfunction

  // Raises start for the coming edge (cycle 0) and queues the expected result.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    @(negedge clk);
    start     = 1'b1;
    mul_op    = op;
    operand_a = a;
    operand_b = b;
    sb_q.push_back(exp);
  endtask

  // Returns the cycle index of result_valid (start cycle = 0), -1 on timeout; scrambles operands meanwhile.
  task automatic wait_valid(output int k, output logic stall_ok);
    stall_ok = 1'b1;
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (result_valid) begin
        k = i;
        if (stall) stall_ok = 1'b0;
        break;
      end
      if (!stall) stall_ok = 1'b0;
      start     = 1'b0;
      operand_a = {$urandom, $urandom};
      operand_b = {$urandom, $urandom};
      mul_op    = 2'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; enable = 1'b1; start = 1'b0; mul_op = 2'b00;
    operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mul_basic();
    int k;
    logic ok;
    logic [W-1:0] exp;
    issue(2'b00, 64'd7, 64'd6, 64'd42);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL basic_stall_c0: got %b expected 1", stall); end
    wait_valid(k, ok);
    exp = pop_expected();
    n_cmp++; if (k !== 65) begin n_bad++; $display("FAIL basic_latency: got %0d expected 65", k); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_stall_window: got %b expected 1", ok); end
    n_cmp++; if (result !== exp) begin n_bad++; $display("FAIL basic_result: got %h expected %h", result, exp); end
    @(negedge clk);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: got %b expected 0", result_valid); end
    n_cmp++; if (result !== 64'd42) begin n_bad++; $display("FAIL basic_hold: got %h expected 2a", result); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_vectors();
    logic [1:0]   ops[6];
    logic [W-1:0] va[6], vb[6], ve[6];
    int k;
    logic ok;
    logic [W-1:0] exp;
    ops[0] = 2'b01; va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'hFFFF_FFFF_FFFF_FFFF; ve[0] = 64'h0;
    ops[1] = 2'b01; va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'h8000_0000_0000_0000; ve[1] = 64'h4000_0000_0000_0000;
    ops[2] = 2'b00; va[2] = 64'hFFFF_FFFF_FFFF_FFFD; vb[2] = 64'd5;                   ve[2] = 64'hFFFF_FFFF_FFFF_FFF1;
    ops[3] = 2'b11; va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'd2;                   ve[3] = 64'd1;
    ops[4] = 2'b10; va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'd2;                   ve[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    ops[5] = 2'b11; va[5] = 64'h0;                   vb[5] = 64'hDEAD_BEEF_1234_5678; ve[5] = 64'h0;
    for (int v = 0; v < 6; v++) begin
      issue(ops[v], va[v], vb[v], ve[v]);
      wait_valid(k, ok);
      exp = pop_expected();
      n_cmp++; if (k !== 65) begin n_bad++; $display("FAIL vec%0d_latency: got %0d expected 65", v, k); end
      n_cmp++; if (result !== exp) begin n_bad++; $display("FAIL vec%0d_result: got %h expected %h", v, result, exp); end
    end
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a, b, exp;
    int k;
    logic ok;
    for (int r = 0; r < 8; r++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (r == 0) a = 64'h8000_0000_0000_0000;
      if (r == 1) b = 64'h8000_0000_0000_0000;
      issue(op, a, b, model(op, a, b));
      wait_valid(k, ok);
      exp = pop_expected();
      n_cmp++; if (result !== exp) begin n_bad++; $display("FAIL rand%0d_result op=%0d: got %h expected %h", r, op, result, exp); end
    end
  endtask

  task automatic test_enable_hold();
    logic [W-1:0] a, b, exp;
    int k, extra;
    a = 64'd123456789;
    b = 64'd987654321;
    k = -1;
    issue(2'b00, a, b, model(2'b00, a, b));
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (result_valid) begin k = i; break; end
      enable    = !(i >= 20 && i <= 29);
      start     = (i == 22 || i == 25 || i == 40 || i == 41);
      operand_a = {$urandom, $urandom};
      operand_b = {$urandom, $urandom};
      mul_op    = 2'($urandom);
    end
    start = 1'b0;
    enable = 1'b1;
    exp = pop_expected();
    n_cmp++; if (k !== 75) begin n_bad++; $display("FAIL en_latency: got %0d expected 75", k); end
    n_cmp++; if (result !== exp) begin n_bad++; $display("FAIL en_result: got %h expected %h", result, exp); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL en_frozen_done: got %b expected 1", result_valid); end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL en_release_done: got %b expected 0", result_valid); end
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (result_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL en_extra_valid: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic ok;
    logic [W-1:0] exp;
    issue(2'b00, 64'h1234, 64'h10, 64'h12340);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    arst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", result_valid); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL midrst_result: got %h expected 0", result); end
    sb_q.delete();
    @(negedge clk);
    arst_n = 1'b1;
    issue(2'b00, 64'd9, 64'd9, 64'd81);
    wait_valid(k, ok);
    exp = pop_expected();
    n_cmp++; if (k !== 65) begin n_bad++; $display("FAIL midrst_latency: got %0d expected 65", k); end
    n_cmp++; if (result !== exp) begin n_bad++; $display("FAIL midrst_result_81: got %h expected %h", result, exp); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, exp1, exp2;
    int k, k2;
    logic ok, hold_ok;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    issue(2'b11, a1, b1, model(2'b11, a1, b1));
    wait_valid(k, ok);
    exp1 = pop_expected();
    n_cmp++; if (k !== 65) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 65", k); end
    n_cmp++; if (result !== exp1) begin n_bad++; $display("FAIL b2b_first_result: got %h expected %h", result, exp1); end
    // start already high in DONE (cycle 65) and held into the IDLE cycle 66
    start = 1'b1; mul_op = 2'b10; operand_a = a2; operand_b = b2;
    sb_q.push_back(model(2'b10, a2, b2));
    hold_ok = 1'b1;
    k2 = -1;
    @(negedge clk);
    if (result !== exp1) hold_ok = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (result !== exp1) hold_ok = 1'b0;
    for (int i = 68; i <= 300; i++) begin
      @(negedge clk);
      if (result_valid) begin k2 = i; break; end
      if (result !== exp1) hold_ok = 1'b0;
      operand_a = {$urandom, $urandom};
      operand_b = {$urandom, $urandom};
    end
    exp2 = pop_expected();
    n_cmp++; if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_first: got %b expected 1", hold_ok); end
    n_cmp++; if (k2 !== 131) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 131", k2); end
    n_cmp++; if (result !== exp2) begin n_bad++; $display("FAIL b2b_second_result: got %h expected %h", result, exp2); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_vectors();
    test_random();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
